lbm_run_sequencer: RTL and testbench
====================================

// Module: lbm_run_sequencer
// PURPOSE
//  Sequences the pipelined LBM solver one timestep at a time and shares the lattice between the solver and host readout.
//  - Gates solver enable per whole timestep and counts completed steps.
//  - Stops after a programmed step target, a single step, or when run drops.
//  - Opens host readout windows only at step boundaries; the solver is never paused mid-step.
//  - In a readout window, drives the readout cell address and captures macroscopic values for GPIO.
// PARAMETERS
//  ADDR_W      12    cell address width (matches RAM_2500 address width)
//  NUM_CELLS   2500  lattice cells; legal addresses are 0..NUM_CELLS-1
//  RD_LATENCY  2     cycles from rd_addr change to valid ux/uy/rho/u2 on the solver outputs
// PORTS
//  clk          in   1      single clock
//  rst          in   1      synchronous reset, active-low (0 = reset, sampled on clk rising edge)
//  run          in   1      level: keep stepping while high
//  single_step  in   1      pulse: run exactly one timestep from IDLE
//  clear_steps  in   1      pulse: zero step_count (effective in IDLE or DONE only)
//  step_target  in   32     stop after this many total steps; 0 = free-run
//  solver_done  in   1      1-cycle pulse from solver: timestep complete
//  host_req     in   1      level, GPIOi[15]: request readout window
//  host_addr    in   15     GPIOi[14:0]: cell to read
//  ux_in, uy_in, rho_in, u2_in  in  16 each  solver macroscopic outputs (signed)
//  solver_en    out  1      enable to the solver
//  step_count   out  32     completed timesteps
//  host_grant   out  1      readout window open; solver is idle
//  rd_addr      out  ADDR_W readout cell address to the solver/RAM read mux
//  gpio_ux, gpio_uy, gpio_rho, gpio_u2  out  16 each  captured values (signed)
//  gpio_valid   out  1      captured values correspond to the latest host_addr
//  addr_err     out  1      sticky per window: host_addr >= NUM_CELLS was seen
//  halted       out  1      step target reached or single step completed
// BEHAVIOUR
//  Reset:
//  - All outputs go to 0 and the state goes to IDLE.
//  - Valid pipeline and return-state register are cleared.
//  - Reset mid-step drops solver_en on the next edge; the count is not preserved.
//  States: IDLE, RUN, HOST, HDRAIN, DONE. All outputs are registered.
//  IDLE:
//  - Transition priority: host_req -> HOST (ret=IDLE); else run|single_step -> RUN.
//  - On the IDLE->RUN transition, latch ss_mode = single_step & ~run.
//  - solver_en rises on the edge that enters RUN.
//  RUN:
//  - solver_en=1. solver_done increments step_count, saturating at 32'hFFFF_FFFF.
//  - On the same solver_done edge, in priority order:
//    1. ss_mode, or (step_target!=0 and incremented count >= step_target) -> DONE.
//    2. host_req -> HOST (ret=IDLE).
//    3. ~run -> IDLE.
//    4. Otherwise stay in RUN.
//  - Leaving RUN clears solver_en on that same edge.
//  - Without solver_done, stay in RUN regardless of run/host_req; the current step always completes.
//  HOST:
//  - host_grant=1, solver_en=0.
//  - Each cycle rd_addr <= host_addr; if host_addr >= NUM_CELLS, use NUM_CELLS-1 instead and set addr_err.
//  - A RD_LATENCY-deep valid shift register tracks reads. gpio_* capture *_in when it emits.
//  - gpio_valid=1 only when no address change occurred in the last RD_LATENCY cycles.
//  - host_req low -> HDRAIN.
//  HDRAIN:
//  - Hold host_grant=1 for RD_LATENCY cycles so in-flight captures complete, then go to ret.
//  - Drop host_grant on exit and clear addr_err.
//  - host_req re-asserting during HDRAIN -> back to HOST.
//  DONE:
//  - halted=1, solver_en=0.
//  - host_req -> HOST (ret=DONE).
//  - run=0 and single_step=0 -> IDLE, clearing halted.
//  Other rules:
//  - solver_done outside RUN is ignored.
//  - clear_steps in RUN/HOST is ignored.
//  - gpio_* hold their last values outside HOST.
//  - step_target changes take effect at the next solver_done.
// TESTING
//  1. Reset with rst=0 for 2 cycles -> every output 0; run=1, target=3, done pulses every 10 cycles -> step_count 1,2,3, halted=1, solver_en=0 after the 3rd.
//  2. In IDLE, pulse single_step -> solver_en high; one done pulse -> step_count=1, DONE state, halted=1.
//  3. host_req=1 mid-step -> solver_en stays 1 until done; next cycle host_grant=1, solver_en=0.
//  4. In HOST, set host_addr=100 with ux_in=16'sh0123 -> gpio_ux=0x0123 and gpio_valid=1 within RD_LATENCY+1 cycles; host_addr=3000 -> rd_addr=2499, addr_err=1.
//  5. Same-cycle solver_done and host_req with target reached -> DONE wins; host then served from DONE and returns to DONE.
//  6. run=1 for 2^32 steps (force count to FFFF_FFFE) -> step_count saturates at FFFF_FFFF.

Source files
------------

// File: rtl/lbm_run_sequencer_if.sv
// Control, host readout and solver handshake bundle for lbm_run_sequencer.
interface lbm_run_sequencer_if #(
    parameter int unsigned ADDR_W = 12
);
    logic               run;
    logic               single_step;
    logic               clear_steps;
    logic [31:0]        step_target;
    logic               solver_done;
    logic               host_req;
    logic [14:0]        host_addr;
    logic signed [15:0] ux_in;
    logic signed [15:0] uy_in;
    logic signed [15:0] rho_in;
    logic signed [15:0] u2_in;

    logic               solver_en;
    logic [31:0]        step_count;
    logic               host_grant;
    logic [ADDR_W-1:0]  rd_addr;
    logic signed [15:0] gpio_ux;
    logic signed [15:0] gpio_uy;
    logic signed [15:0] gpio_rho;
    logic signed [15:0] gpio_u2;
    logic               gpio_valid;
    logic               addr_err;
    logic               halted;

    // Host/solver side driving the sequencer.
    modport master (
        output run, single_step, clear_steps, step_target, solver_done,
               host_req, host_addr, ux_in, uy_in, rho_in, u2_in,
        input  solver_en, step_count, host_grant, rd_addr, gpio_ux, gpio_uy,
               gpio_rho, gpio_u2, gpio_valid, addr_err, halted
    );

    // The sequencer itself.
    modport slave (
        input  run, single_step, clear_steps, step_target, solver_done,
               host_req, host_addr, ux_in, uy_in, rho_in, u2_in,
        output solver_en, step_count, host_grant, rd_addr, gpio_ux, gpio_uy,
               gpio_rho, gpio_u2, gpio_valid, addr_err, halted
    );
endinterface

// File: rtl/lbm_run_sequencer.sv
// Steps the LBM solver one whole timestep at a time and opens host readout
// windows only at step boundaries.
module lbm_run_sequencer #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned NUM_CELLS  = 2500,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    lbm_run_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_HOST, S_HDRAIN, S_DONE} state_t;

    state_t                state_q, state_d, ret_q, ret_d;
    logic                  ss_q, ss_d;
    logic [31:0]           cnt_q, cnt_d, cnt_inc;
    logic                  en_q, en_d, grant_q, grant_d, halted_q, halted_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                  err_q, err_d, oor, addr_chg;
    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]      drain_q, drain_d, age_q, age_d;
    logic                  valid_q, valid_d;
    logic signed [15:0]    ux_q, uy_q, rho_q, u2_q;

    // Next state, step counting and readout address/valid tracking.
    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        ss_d     = ss_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        rd_addr_d = rd_addr_q;
        err_d    = err_q;
        addr_chg = 1'b0;
        valid_d  = valid_q;
        age_d    = age_q;
        cnt_inc  = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        oor      = 32'(bus.host_addr) >= 32'(NUM_CELLS);

        case (state_q)
            S_IDLE: begin
                if (bus.clear_steps) cnt_d = '0;
                if (bus.host_req) begin
                    state_d = S_HOST;
                    ret_d   = S_IDLE;
                end else if (bus.run || bus.single_step) begin
                    state_d = S_RUN;
                    ss_d    = bus.single_step & ~bus.run;
                end
            end
            S_RUN: begin
                if (bus.solver_done) begin
                    cnt_d = cnt_inc;
                    if (ss_q || (bus.step_target != 32'd0 && cnt_inc >= bus.step_target)) begin
                        state_d = S_DONE;
                    end else if (bus.host_req) begin
                        state_d = S_HOST;
                        ret_d   = S_IDLE;
                    end else if (!bus.run) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOST: begin
                if (!bus.host_req) begin
                    state_d = S_HDRAIN;
                    drain_d = '0;
                end
            end
            S_HDRAIN: begin
                if (bus.host_req) begin
                    state_d = S_HOST;
                end else if (drain_q == CNT_W'(RD_LATENCY - 1)) begin
                    state_d = ret_q;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.clear_steps) cnt_d = '0;
                if (bus.host_req) begin
                    state_d = S_HOST;
                    ret_d   = S_DONE;
                end else if (!bus.run && !bus.single_step) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        en_d     = (state_d == S_RUN);
        grant_d  = (state_d == S_HOST) || (state_d == S_HDRAIN);
        halted_d = (state_d == S_DONE) || (grant_d && ret_d == S_DONE);

        // Readout address follows host_addr only while the window is open.
        if (state_q == S_HOST) begin
            rd_addr_d = oor ? LAST_ADDR : ADDR_W'(bus.host_addr);
            err_d     = err_q | oor;
            addr_chg  = (rd_addr_d != rd_addr_q);
        end
        if (!grant_d) err_d = 1'b0;

        // Cycles since the readout address last moved; restarts outside a window.
        if (!grant_q || addr_chg) age_d = '0;
        else if (age_q != CNT_W'(RD_LATENCY)) age_d = age_q + CNT_W'(1);

        // Each read issued in HOST emerges RD_LATENCY cycles later.
        vld_d = (vld_q << 1) | RD_LATENCY'(state_q == S_HOST);

        if (vld_q[RD_LATENCY-1]) valid_d = (age_q >= CNT_W'(RD_LATENCY - 1)) && !addr_chg;
        else if (addr_chg)       valid_d = 1'b0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            ss_q      <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            grant_q   <= 1'b0;
            halted_q  <= 1'b0;
            rd_addr_q <= '0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            drain_q   <= '0;
            age_q     <= '0;
            valid_q   <= 1'b0;
            ux_q      <= '0;
            uy_q      <= '0;
            rho_q     <= '0;
            u2_q      <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            ss_q      <= ss_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            grant_q   <= grant_d;
            halted_q  <= halted_d;
            rd_addr_q <= rd_addr_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            drain_q   <= drain_d;
            age_q     <= age_d;
            valid_q   <= valid_d;
            if (vld_q[RD_LATENCY-1]) begin
                ux_q  <= bus.ux_in;
                uy_q  <= bus.uy_in;
                rho_q <= bus.rho_in;
                u2_q  <= bus.u2_in;
            end
        end
    end

    assign bus.solver_en  = en_q;
    assign bus.step_count = cnt_q;
    assign bus.host_grant = grant_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.gpio_ux    = ux_q;
    assign bus.gpio_uy    = uy_q;
    assign bus.gpio_rho   = rho_q;
    assign bus.gpio_u2    = u2_q;
    assign bus.gpio_valid = valid_q;
    assign bus.addr_err   = err_q;
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_lbm_run_sequencer.sv
// Directed-vector bench for lbm_run_sequencer.
module tb_lbm_run_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    lbm_run_sequencer_if #(.ADDR_W(12)) bus ();

    lbm_run_sequencer #(.ADDR_W(12), .NUM_CELLS(2500), .RD_LATENCY(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        bus.solver_done = 1'b1;
        @(negedge clk);
        bus.solver_done = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        bus.run         = 1'b0;
        bus.single_step = 1'b0;
        bus.clear_steps = 1'b0;
        bus.step_target = 32'd0;
        bus.solver_done = 1'b0;
        bus.host_req    = 1'b0;
        bus.host_addr   = 15'd0;
        bus.ux_in       = 16'sh0000;
        bus.uy_in       = 16'sh0000;
        bus.rho_in      = 16'sh0000;
        bus.u2_in       = 16'sh0000;
        cycles(2);

        // Reset values
        check("rst_en",     32'(bus.solver_en), 32'd0);
        check("rst_cnt",    bus.step_count,     32'd0);
        check("rst_grant",  32'(bus.host_grant), 32'd0);
        check("rst_addr",   32'(bus.rd_addr),   32'd0);
        check("rst_ux",     {16'h0, bus.gpio_ux}, 32'd0);
        check("rst_valid",  32'(bus.gpio_valid), 32'd0);
        check("rst_err",    32'(bus.addr_err),  32'd0);
        check("rst_halted", 32'(bus.halted),    32'd0);
        rst = 1'b1;

        // Run to a target of 3 steps
        bus.step_target = 32'd3;
        bus.run         = 1'b1;
        cycles(1);
        check("t1_en_rise", 32'(bus.solver_en), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            cycles(9);
            pulse_done();
            check("t1_cnt", bus.step_count, 32'(k));
            check("t1_en",  32'(bus.solver_en), (k < 3) ? 32'd1 : 32'd0);
        end
        check("t1_halted", 32'(bus.halted), 32'd1);
        pulse_done();
        check("t1_done_ignored", bus.step_count, 32'd3);
        bus.run = 1'b0;
        cycles(1);
        check("t1_idle_halted", 32'(bus.halted), 32'd0);
        bus.clear_steps = 1'b1;
        cycles(1);
        bus.clear_steps = 1'b0;
        check("t1_clear", bus.step_count, 32'd0);

        // Single step
        bus.single_step = 1'b1;
        cycles(1);
        bus.single_step = 1'b0;
        check("t2_en", 32'(bus.solver_en), 32'd1);
        cycles(4);
        pulse_done();
        check("t2_cnt",    bus.step_count,      32'd1);
        check("t2_halted", 32'(bus.halted),     32'd1);
        check("t2_en_off", 32'(bus.solver_en),  32'd0);
        cycles(1);
        check("t2_idle", 32'(bus.halted), 32'd0);

        // Host request arrives mid-step
        bus.step_target = 32'd0;
        bus.run         = 1'b1;
        cycles(4);
        bus.host_req = 1'b1;
        cycles(3);
        check("t3_en_hold",   32'(bus.solver_en),  32'd1);
        check("t3_no_grant",  32'(bus.host_grant), 32'd0);
        pulse_done();
        check("t3_cnt",   bus.step_count,      32'd2);
        check("t3_en",    32'(bus.solver_en),  32'd0);
        check("t3_grant", 32'(bus.host_grant), 32'd1);

        // Readout inside the window
        bus.host_addr = 15'd100;
        bus.ux_in     = 16'sh0123;
        bus.uy_in     = -16'sd5;
        bus.rho_in    = 16'sh1000;
        bus.u2_in     = 16'sh0042;
        cycles(3);
        check("t4_addr",  32'(bus.rd_addr),    32'd100);
        check("t4_ux",    {16'h0, bus.gpio_ux},  32'h0000_0123);
        check("t4_uy",    {16'h0, bus.gpio_uy},  32'h0000_FFFB);
        check("t4_rho",   {16'h0, bus.gpio_rho}, 32'h0000_1000);
        check("t4_u2",    {16'h0, bus.gpio_u2},  32'h0000_0042);
        check("t4_valid", 32'(bus.gpio_valid), 32'd1);
        bus.host_addr = 15'd200;
        cycles(1);
        check("t4_valid_drop", 32'(bus.gpio_valid), 32'd0);
        bus.host_addr = 15'd2499;
        cycles(1);
        check("t4_last_addr", 32'(bus.rd_addr),  32'd2499);
        check("t4_last_err",  32'(bus.addr_err), 32'd0);
        bus.host_addr = 15'd2500;
        cycles(1);
        check("t4_oob_addr", 32'(bus.rd_addr),  32'd2499);
        check("t4_oob_err",  32'(bus.addr_err), 32'd1);
        bus.host_addr = 15'd3000;
        cycles(1);
        check("t4_3000_addr", 32'(bus.rd_addr),  32'd2499);
        check("t4_3000_err",  32'(bus.addr_err), 32'd1);
        cycles(3);
        check("t4_valid_again", 32'(bus.gpio_valid), 32'd1);
        bus.host_req = 1'b0;
        bus.run      = 1'b0;
        cycles(1);
        check("t4_drain_grant", 32'(bus.host_grant), 32'd1);
        cycles(1);
        check("t4_drain_grant2", 32'(bus.host_grant), 32'd1);
        cycles(1);
        check("t4_exit_grant", 32'(bus.host_grant), 32'd0);
        check("t4_exit_err",   32'(bus.addr_err),   32'd0);
        bus.ux_in = 16'sh7777;
        cycles(2);
        check("t4_gpio_hold", {16'h0, bus.gpio_ux}, 32'h0000_0123);

        // Target reached and host request on the same edge
        bus.step_target = 32'd3;
        bus.run         = 1'b1;
        cycles(3);
        bus.host_req = 1'b1;
        pulse_done();
        check("t5_cnt",    bus.step_count,      32'd3);
        check("t5_halted", 32'(bus.halted),     32'd1);
        check("t5_nogrant", 32'(bus.host_grant), 32'd0);
        cycles(1);
        check("t5_grant", 32'(bus.host_grant), 32'd1);
        check("t5_en",    32'(bus.solver_en),  32'd0);
        bus.host_req = 1'b0;
        cycles(3);
        check("t5_ret_grant",  32'(bus.host_grant), 32'd0);
        check("t5_ret_halted", 32'(bus.halted),     32'd1);
        cycles(1);
        check("t5_stay_done", 32'(bus.halted),    32'd1);
        check("t5_stay_en",   32'(bus.solver_en), 32'd0);
        bus.run = 1'b0;
        cycles(1);
        check("t5_idle", 32'(bus.halted), 32'd0);

        // Count saturation
        bus.step_target = 32'd0;
        bus.run         = 1'b1;
        cycles(1);
        force dut.cnt_q = 32'hFFFF_FFFE;
        cycles(1);
        release dut.cnt_q;
        cycles(1);
        check("t6_preload", bus.step_count, 32'hFFFF_FFFE);
        pulse_done();
        check("t6_max", bus.step_count, 32'hFFFF_FFFF);
        cycles(2);
        pulse_done();
        check("t6_sat",    bus.step_count,     32'hFFFF_FFFF);
        check("t6_run_on", 32'(bus.solver_en), 32'd1);
        check("t6_halted", 32'(bus.halted),    32'd0);
        bus.run = 1'b0;
        pulse_done();
        check("t6_stop", 32'(bus.solver_en), 32'd0);

        // Reset mid-step
        bus.run = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(1);
        check("t7_rst_en",  32'(bus.solver_en), 32'd0);
        check("t7_rst_cnt", bus.step_count,     32'd0);
        rst     = 1'b1;
        bus.run = 1'b0;
        cycles(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
